// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// Each requester runs one req/ack handshake per 32-bit read or write; the
// arbiter serialises them as IDLE -> ACCESS -> DONE. All outputs are registered.
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // Last ACCESS cycle of a read: data_out is valid RD_LAT cycles after the
  // address went out, which is the (RD_LAT+1)-th ACCESS edge.
  localparam logic [1:0] LP_LAST = 2'(RD_LAT);

  state_t        r_state;
  logic          r_rr;
  logic          r_we;
  logic [1:0]    r_cnt;
  logic          r_ack0, r_ack1;
  logic [DW-1:0] r_rdata0, r_rdata1;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_wr_en;
  logic [DW-1:0] r_mem_data_in;
  logic          r_busy;
  logic          r_grant_id;

  logic          w_any;
  logic          w_win;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // A lone requester wins outright; on contention the rr pointer decides.
  assign w_any   = req0 | req1;
  assign w_win   = (req0 & req1) ? r_rr : req1;
  assign w_we    = w_win ? we1    : we0;
  assign w_addr  = w_win ? addr1  : addr0;
  assign w_wdata = w_win ? wdata1 : wdata0;

  // Arbitration FSM; a reset edge aborts any transaction without an ack.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_rr          <= 1'b0;
      r_we          <= 1'b0;
      r_cnt         <= '0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_mem_addr    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_data_in <= '0;
      r_busy        <= 1'b0;
      r_grant_id    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id    <= w_win;
            r_we          <= w_we;
            r_mem_addr    <= w_addr;
            r_mem_data_in <= w_wdata;
            r_mem_wr_en   <= w_we;
            r_busy        <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            // Write strobe is exactly the single ACCESS cycle.
            r_mem_wr_en <= 1'b0;
            r_ack0      <= ~r_grant_id;
            r_ack1      <= r_grant_id;
            r_state     <= S_DONE;
          end else if (r_cnt == LP_LAST) begin
            if (r_grant_id) r_rdata1 <= mem_data_out;
            else            r_rdata0 <= mem_data_out;
            r_ack0  <= ~r_grant_id;
            r_ack1  <= r_grant_id;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_rr    <= ~r_grant_id;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_data_in = r_mem_data_in;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;

endmodule
